// File: rtl/ct_idu_id_fence_split_ctrl_if.sv
// ID-stage to fence/split sequencer signal bundle: decode inputs, RTU status and uop outputs.
// master drives the ID/RTU/IR side, slave is the sequencer itself.
interface ct_idu_id_fence_split_ctrl_if #(
  parameter int unsigned IDX_W = 2
);
  logic             id_inst_vld;
  logic             id_inst_fence;
  logic             id_inst_split;
  logic [IDX_W-1:0] id_split_cnt;
  logic             ir_id_stall;
  logic             rtu_idu_rob_empty;
  logic             rtu_idu_fence_cmplt;
  logic             rtu_idu_flush;
  logic             idu_uop_vld;
  logic [IDX_W-1:0] idu_uop_idx;
  logic             idu_uop_last;
  logic             idu_uop_fence;
  logic             idu_id_stall;
  logic             idu_ctrl_busy;

  modport master (
    output id_inst_vld, id_inst_fence, id_inst_split, id_split_cnt, ir_id_stall,
           rtu_idu_rob_empty, rtu_idu_fence_cmplt, rtu_idu_flush,
    input  idu_uop_vld, idu_uop_idx, idu_uop_last, idu_uop_fence, idu_id_stall,
           idu_ctrl_busy
  );

  modport slave (
    input  id_inst_vld, id_inst_fence, id_inst_split, id_split_cnt, ir_id_stall,
           rtu_idu_rob_empty, rtu_idu_fence_cmplt, rtu_idu_flush,
    output idu_uop_vld, idu_uop_idx, idu_uop_last, idu_uop_fence, idu_id_stall,
           idu_ctrl_busy
  );
endinterface

// File: rtl/ct_idu_id_fence_split_ctrl.sv
// ID-stage sequencer: splits long instructions into micro-ops and serialises fences
// against an empty ROB, holding younger instructions until the fence retires.
module ct_idu_id_fence_split_ctrl #(
  parameter int unsigned SPLIT_MAX = 4,
  parameter int unsigned IDX_W     = $clog2(SPLIT_MAX)
) (
  input logic                         cpuclk,
  input logic                         cpurst_b,
  ct_idu_id_fence_split_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StSplit, StFwait, StFdrain} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] lat_q, lat_d;

  logic             uop_vld;
  logic [IDX_W-1:0] uop_idx;
  logic             uop_last;
  logic             uop_fence;
  logic             id_stall;
  logic             accept;
  logic             split_start;

  assign split_start = bus.id_inst_split && (bus.id_split_cnt != '0);

  always_ff @(posedge cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    unique case (state_q)
      StIdle: begin
        if (bus.id_inst_vld && bus.id_inst_fence) begin
          state_d = StFwait;
        end else if (bus.id_inst_vld && split_start && accept) begin
          state_d = StSplit;
          cnt_d   = IDX_W'(1);
          lat_d   = bus.id_split_cnt;
        end
      end
      StSplit: begin
        if (accept) begin
          if (uop_last) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + IDX_W'(1);
          end
        end
      end
      StFwait: begin
        if (accept) state_d = StFdrain;
      end
      StFdrain: begin
        if (bus.rtu_idu_fence_cmplt) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Flush beats any accept or fence completion seen in the same cycle.
    if (bus.rtu_idu_flush) begin
      state_d = StIdle;
      cnt_d   = '0;
    end
  end

  always_comb begin
    uop_vld   = 1'b0;
    uop_idx   = '0;
    uop_last  = 1'b0;
    uop_fence = 1'b0;
    id_stall  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.id_inst_vld) begin
          if (bus.id_inst_fence) begin
            id_stall = 1'b1;
          end else if (split_start) begin
            uop_vld  = 1'b1;
            id_stall = 1'b1;
          end else begin
            uop_vld  = 1'b1;
            uop_last = 1'b1;
            id_stall = bus.ir_id_stall;
          end
        end
      end
      StSplit: begin
        uop_vld  = 1'b1;
        uop_idx  = cnt_q;
        uop_last = (cnt_q == lat_q);
      end
      StFwait: begin
        uop_vld   = bus.rtu_idu_rob_empty;
        uop_last  = 1'b1;
        uop_fence = 1'b1;
      end
      StFdrain: id_stall = 1'b1;
      default: ;
    endcase
    if (bus.rtu_idu_flush) uop_vld = 1'b0;
    accept = uop_vld && !bus.ir_id_stall;
    if (state_q == StSplit) id_stall = !(uop_last && accept);
    if (state_q == StFwait) id_stall = !accept;
  end

  // Outputs are forced low for the whole reset assertion, not just from the next edge.
  assign bus.idu_uop_vld   = cpurst_b && uop_vld;
  assign bus.idu_uop_idx   = cpurst_b ? uop_idx : '0;
  assign bus.idu_uop_last  = cpurst_b && uop_last;
  assign bus.idu_uop_fence = cpurst_b && uop_fence;
  assign bus.idu_id_stall  = cpurst_b && id_stall;
  assign bus.idu_ctrl_busy = cpurst_b && (state_q != StIdle);

endmodule

// File: tb/tb_ct_idu_id_fence_split_ctrl.sv
// Vector-table bench for the fence/split sequencer; expected outputs are queued per cycle
// and compared against the DUT outputs shortly before the next rising edge.
module tb_ct_idu_id_fence_split_ctrl;

  logic cpuclk;
  logic cpurst_b;

  ct_idu_id_fence_split_ctrl_if #(.IDX_W(2)) bus ();

  ct_idu_id_fence_split_ctrl #(
    .SPLIT_MAX(4),
    .IDX_W    (2)
  ) dut (
    .cpuclk  (cpuclk),
    .cpurst_b(cpurst_b),
    .bus     (bus)
  );

  initial begin
    cpuclk = 1'b0;
    forever #5 cpuclk = ~cpuclk;
  end

  typedef struct {
    string      name;
    logic       rstn;
    logic       vld;
    logic       fen;
    logic       spl;
    logic [1:0] scnt;
    logic       irs;
    logic       rob;
    logic       cmp;
    logic       fl;
    logic [6:0] exp;  // {vld, idx[1:0], last, fence, stall, busy}
  } vec_t;

  vec_t       vecs[$];
  logic [6:0] exp_q[$];
  string      name_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;

  function automatic vec_t mk(string name, logic rstn, logic vld, logic fen, logic spl,
                              logic [1:0] scnt, logic irs, logic rob, logic cmp, logic fl,
                              logic [6:0] exp);
    vec_t v;
    v.name = name; v.rstn = rstn; v.vld = vld; v.fen = fen; v.spl = spl; v.scnt = scnt;
    v.irs = irs; v.rob = rob; v.cmp = cmp; v.fl = fl; v.exp = exp;
    return v;
  endfunction

  task automatic check_out();
    logic [6:0] got;
    logic [6:0] want;
    string      nm;
    got  = {bus.idu_uop_vld, bus.idu_uop_idx, bus.idu_uop_last, bus.idu_uop_fence,
            bus.idu_id_stall, bus.idu_ctrl_busy};
    want = exp_q.pop_front();
    nm   = name_q.pop_front();
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (vld,idx,last,fence,stall,busy)", nm, got, want);
    end
  endtask

  // Drive one cycle of stimulus just after the falling edge, sample before the rising edge.
  task automatic apply(input vec_t v);
    @(negedge cpuclk);
    cpurst_b                = v.rstn;
    bus.id_inst_vld         = v.vld;
    bus.id_inst_fence       = v.fen;
    bus.id_inst_split       = v.spl;
    bus.id_split_cnt        = v.scnt;
    bus.ir_id_stall         = v.irs;
    bus.rtu_idu_rob_empty   = v.rob;
    bus.rtu_idu_fence_cmplt = v.cmp;
    bus.rtu_idu_flush       = v.fl;
    exp_q.push_back(v.exp);
    name_q.push_back(v.name);
    #3;
    check_out();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cpurst_b                = 1'b0;
    bus.id_inst_vld         = 1'b0;
    bus.id_inst_fence       = 1'b0;
    bus.id_inst_split       = 1'b0;
    bus.id_split_cnt        = 2'd0;
    bus.ir_id_stall         = 1'b0;
    bus.rtu_idu_rob_empty   = 1'b0;
    bus.rtu_idu_fence_cmplt = 1'b0;
    bus.rtu_idu_flush       = 1'b0;

    //                  name             rst vld fen spl scnt irs rob cmp fl  expected
    vecs.push_back(mk("reset_vld",        0,  1,  0,  0, 2'd0, 0,  0,  0,  0, 7'b0_00_0_0_0_0));
    vecs.push_back(mk("rst_release",      1,  0,  0,  0, 2'd0, 0,  0,  0,  0, 7'b0_00_0_0_0_0));
    vecs.push_back(mk("normal",           1,  1,  0,  0, 2'd0, 0,  0,  0,  0, 7'b1_00_1_0_0_0));
    vecs.push_back(mk("normal_irstall",   1,  1,  0,  0, 2'd0, 1,  0,  0,  0, 7'b1_00_1_0_1_0));
    vecs.push_back(mk("split0_normal",    1,  1,  0,  1, 2'd0, 0,  0,  0,  0, 7'b1_00_1_0_0_0));
    vecs.push_back(mk("cmplt_idle_ign",   1,  0,  0,  0, 2'd0, 0,  0,  1,  0, 7'b0_00_0_0_0_0));
    vecs.push_back(mk("amo_u0",           1,  1,  0,  1, 2'd1, 0,  0,  0,  0, 7'b1_00_0_0_1_0));
    vecs.push_back(mk("amo_u1_stall",     1,  1,  0,  1, 2'd1, 1,  0,  0,  0, 7'b1_01_1_0_1_1));
    vecs.push_back(mk("amo_u1_acc",       1,  1,  0,  1, 2'd1, 0,  0,  0,  0, 7'b1_01_1_0_0_1));
    vecs.push_back(mk("amo_done",         1,  0,  0,  0, 2'd0, 0,  0,  0,  0, 7'b0_00_0_0_0_0));
    vecs.push_back(mk("fence_idle",       1,  1,  1,  0, 2'd0, 0,  0,  0,  0, 7'b0_00_0_0_1_0));
    vecs.push_back(mk("fwait_busy1",      1,  1,  1,  0, 2'd0, 0,  0,  0,  0, 7'b0_00_1_1_1_1));
    vecs.push_back(mk("fwait_busy2",      1,  1,  1,  0, 2'd0, 0,  0,  1,  0, 7'b0_00_1_1_1_1));
    vecs.push_back(mk("fwait_busy3",      1,  1,  1,  0, 2'd0, 0,  0,  0,  0, 7'b0_00_1_1_1_1));
    vecs.push_back(mk("fwait_busy4",      1,  1,  1,  0, 2'd0, 0,  0,  0,  0, 7'b0_00_1_1_1_1));
    vecs.push_back(mk("fwait_ir_stall",   1,  1,  1,  0, 2'd0, 1,  1,  0,  0, 7'b1_00_1_1_1_1));
    vecs.push_back(mk("fence_issue",      1,  1,  1,  0, 2'd0, 0,  1,  0,  0, 7'b1_00_1_1_0_1));
    vecs.push_back(mk("fdrain_hold1",     1,  1,  0,  0, 2'd0, 0,  1,  0,  0, 7'b0_00_0_0_1_1));
    vecs.push_back(mk("fdrain_hold2",     1,  1,  0,  0, 2'd0, 0,  1,  0,  0, 7'b0_00_0_0_1_1));
    vecs.push_back(mk("fdrain_cmplt",     1,  1,  0,  0, 2'd0, 0,  1,  1,  0, 7'b0_00_0_0_1_1));
    vecs.push_back(mk("post_fence",       1,  1,  0,  0, 2'd0, 0,  1,  0,  0, 7'b1_00_1_0_0_0));
    vecs.push_back(mk("fence2_idle",      1,  1,  1,  0, 2'd0, 0,  0,  0,  0, 7'b0_00_0_0_1_0));
    vecs.push_back(mk("flush_fwait",      1,  1,  1,  0, 2'd0, 0,  1,  0,  1, 7'b0_00_1_1_1_1));
    vecs.push_back(mk("post_flush_fw",    1,  0,  0,  0, 2'd0, 0,  1,  0,  0, 7'b0_00_0_0_0_0));
    vecs.push_back(mk("s3_u0",            1,  1,  0,  1, 2'd3, 0,  0,  0,  0, 7'b1_00_0_0_1_0));
    vecs.push_back(mk("flush_split",      1,  1,  0,  1, 2'd3, 0,  0,  0,  1, 7'b0_01_0_0_1_1));
    vecs.push_back(mk("post_flush_sp",    1,  1,  0,  0, 2'd0, 0,  0,  0,  0, 7'b1_00_1_0_0_0));
    vecs.push_back(mk("fs_idle",          1,  1,  1,  1, 2'd3, 0,  0,  0,  0, 7'b0_00_0_0_1_0));
    vecs.push_back(mk("fs_issue",         1,  1,  1,  1, 2'd3, 0,  1,  0,  0, 7'b1_00_1_1_0_1));
    vecs.push_back(mk("fs_drain",         1,  0,  0,  0, 2'd0, 0,  1,  0,  0, 7'b0_00_0_0_1_1));
    vecs.push_back(mk("fs_cmplt",         1,  0,  0,  0, 2'd0, 0,  1,  1,  0, 7'b0_00_0_0_1_1));
    vecs.push_back(mk("fs_after",         1,  0,  0,  0, 2'd0, 0,  1,  0,  0, 7'b0_00_0_0_0_0));
    vecs.push_back(mk("s4_u0",            1,  1,  0,  1, 2'd3, 0,  0,  0,  0, 7'b1_00_0_0_1_0));
    vecs.push_back(mk("s4_u1",            1,  0,  0,  0, 2'd0, 0,  0,  0,  0, 7'b1_01_0_0_1_1));
    vecs.push_back(mk("s4_u2",            1,  1,  1,  0, 2'd1, 0,  0,  0,  0, 7'b1_10_0_0_1_1));
    vecs.push_back(mk("s4_u3",            1,  1,  0,  1, 2'd3, 0,  0,  0,  0, 7'b1_11_1_0_0_1));
    vecs.push_back(mk("s4_done",          1,  0,  0,  0, 2'd0, 0,  0,  0,  0, 7'b0_00_0_0_0_0));

    foreach (vecs[i]) apply(vecs[i]);

    // Asynchronous reset taken while a split sits at cnt=2.
    apply(mk("rs_u0",                     1,  1,  0,  1, 2'd3, 0,  0,  0,  0, 7'b1_00_0_0_1_0));
    apply(mk("rs_u1",                     1,  1,  0,  1, 2'd3, 0,  0,  0,  0, 7'b1_01_0_0_1_1));
    apply(mk("rs_assert",                 0,  1,  0,  1, 2'd3, 0,  0,  0,  0, 7'b0_00_0_0_0_0));
    apply(mk("rs_release",                1,  0,  0,  0, 2'd0, 0,  0,  0,  0, 7'b0_00_0_0_0_0));
    apply(mk("rs_restart",                1,  1,  0,  1, 2'd3, 0,  0,  0,  0, 7'b1_00_0_0_1_0));
    apply(mk("rs_restart_u1",             1,  1,  0,  1, 2'd3, 1,  0,  0,  0, 7'b1_01_0_0_1_1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
